// File: rtl/alu_issue_ctrl_pkg.sv
// Shared definitions for the ALU issue controller: opcode constants, FSM states and default widths.
package alu_issue_ctrl_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int REG_AW_DEF = 5;

   localparam logic [3:0] OP_AND  = 4'd0;
   localparam logic [3:0] OP_OR   = 4'd1;
   localparam logic [3:0] OP_ADD  = 4'd2;
   localparam logic [3:0] OP_SUB  = 4'd6;
   localparam logic [3:0] OP_MIN  = 4'd7;
   localparam logic [3:0] OP_NOR  = 4'd12;
   localparam logic [3:0] OP_NAND = 4'd13;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_EXEC,
      ST_WB
   } state_e;

   // Width of the ALU wait counter: must hold ALU_LAT, never narrower than one bit.
   function automatic int wait_cnt_w(input int lat);
      return (lat < 2) ? 1 : $clog2(lat + 1);
   endfunction

endpackage

// File: rtl/alu_issue_ctrl.sv
// Initiator side of the ALU interface: fetches operands from the register file, issues them to a
// clocked ALU, waits ALU_LAT edges, and writes the result back to the destination register.
module alu_issue_ctrl
   import alu_issue_ctrl_pkg::*;
#(
   parameter int DATA_W  = DATA_W_DEF,
   parameter int REG_AW  = REG_AW_DEF,
   parameter int ALU_LAT = 1,
   parameter int R0_ZERO = 1,
   parameter int CNT_W   = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              instr_valid,
   output logic              instr_ready,
   input  logic [3:0]        instr_op,
   input  logic [REG_AW-1:0] instr_rd,
   input  logic [REG_AW-1:0] instr_rs,
   input  logic [REG_AW-1:0] instr_rt,
   output logic [REG_AW-1:0] rf_raddr1,
   output logic [REG_AW-1:0] rf_raddr2,
   input  logic [DATA_W-1:0] rf_rdata1,
   input  logic [DATA_W-1:0] rf_rdata2,
   output logic [3:0]        alu_opcode,
   output logic [DATA_W-1:0] alu_in1,
   output logic [DATA_W-1:0] alu_in2,
   input  logic [DATA_W-1:0] alu_result,
   output logic              rf_we,
   output logic [REG_AW-1:0] rf_waddr,
   output logic [DATA_W-1:0] rf_wdata,
   output logic              done,
   output logic              busy,
   output logic [CNT_W-1:0]  retired_cnt
);

   localparam int CW = wait_cnt_w(ALU_LAT);

   state_e            state_q, state_d;
   logic [3:0]        op_q, op_d;
   logic [REG_AW-1:0] rd_q, rd_d, rs_q, rs_d, rt_q, rt_d;
   logic [CW-1:0]     wcnt_q, wcnt_d;
   logic [3:0]        alu_opcode_q, alu_opcode_d;
   logic [DATA_W-1:0] alu_in1_q, alu_in1_d, alu_in2_q, alu_in2_d;
   logic              rf_we_q, rf_we_d, done_q, done_d;
   logic [REG_AW-1:0] rf_waddr_q, rf_waddr_d;
   logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
   logic [CNT_W-1:0]  retired_cnt_q, retired_cnt_d;

   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
      state_d       = state_q;
      op_d          = op_q;
      rd_d          = rd_q;
      rs_d          = rs_q;
      rt_d          = rt_q;
      wcnt_d        = wcnt_q;
      alu_opcode_d  = alu_opcode_q;
      alu_in1_d     = alu_in1_q;
      alu_in2_d     = alu_in2_q;
      rf_we_d       = 1'b0;
      done_d        = 1'b0;
      rf_waddr_d    = rf_waddr_q;
      rf_wdata_d    = rf_wdata_q;
      retired_cnt_d = retired_cnt_q;

      unique case (state_q)
         ST_IDLE: begin
            if (instr_valid && instr_ready) begin
               op_d    = instr_op;
               rd_d    = instr_rd;
               rs_d    = instr_rs;
               rt_d    = instr_rt;
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            alu_opcode_d = op_q;
            alu_in1_d    = rf_rdata1;
            alu_in2_d    = rf_rdata2;
            wcnt_d       = CW'(ALU_LAT);
            state_d      = ST_EXEC;
         end
         ST_EXEC: begin
            if (wcnt_q == CW'(1)) state_d = ST_WB;
            else                  wcnt_d  = wcnt_q - CW'(1);
         end
         ST_WB: begin
            // The ALU result is valid throughout WB; capturing it on the edge leaving WB puts the
            // write in the following cycle, which still lands before the next ISSUE reads.
            rf_wdata_d    = alu_result;
            rf_waddr_d    = rd_q;
            rf_we_d       = !((R0_ZERO != 0) && (rd_q == '0));
            done_d        = 1'b1;
            retired_cnt_d = retired_cnt_q + CNT_W'(1);
            state_d       = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: datapath registers are reset too, because their reset values are visible on the ports.
      if (rst) begin
         state_q       <= ST_IDLE;
         op_q          <= '0;
         rd_q          <= '0;
         rs_q          <= '0;
         rt_q          <= '0;
         wcnt_q        <= '0;
         alu_opcode_q  <= '0;
         alu_in1_q     <= '0;
         alu_in2_q     <= '0;
         rf_we_q       <= 1'b0;
         done_q        <= 1'b0;
         rf_waddr_q    <= '0;
         rf_wdata_q    <= '0;
         retired_cnt_q <= '0;
      end else begin
         // NOTE: non-blocking so every flop samples pre-edge values regardless of statement order.
         state_q       <= state_d;
         op_q          <= op_d;
         rd_q          <= rd_d;
         rs_q          <= rs_d;
         rt_q          <= rt_d;
         wcnt_q        <= wcnt_d;
         alu_opcode_q  <= alu_opcode_d;
         alu_in1_q     <= alu_in1_d;
         alu_in2_q     <= alu_in2_d;
         rf_we_q       <= rf_we_d;
         done_q        <= done_d;
         rf_waddr_q    <= rf_waddr_d;
         rf_wdata_q    <= rf_wdata_d;
         retired_cnt_q <= retired_cnt_d;
      end
   end

   assign instr_ready = (state_q == ST_IDLE);
   assign busy        = (state_q != ST_IDLE);
   assign rf_raddr1   = rs_q;
   assign rf_raddr2   = rt_q;
   assign alu_opcode  = alu_opcode_q;
   assign alu_in1     = alu_in1_q;
   assign alu_in2     = alu_in2_q;
   assign rf_we       = rf_we_q;
   assign rf_waddr    = rf_waddr_q;
   assign rf_wdata    = rf_wdata_q;
   assign done        = done_q;
   assign retired_cnt = retired_cnt_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: two instances (ALU_LAT=1/CNT_W=16 and ALU_LAT=3/CNT_W=4), each with its
// own register file and clocked ALU, checked every cycle against a transaction-level model.
module tb_alu_issue_ctrl;
   import alu_issue_ctrl_pkg::*;

   localparam int LAT  [2] = '{1, 3};
   localparam int CMOD [2] = '{65536, 16};

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst [2];
   logic        iv [2], ir [2];
   logic [3:0]  iop [2];
   logic [4:0]  ird [2], irs [2], irt [2];
   logic [4:0]  ra1 [2], ra2 [2];
   logic [31:0] rd1 [2], rd2 [2];
   logic [3:0]  aop [2];
   logic [31:0] ain1 [2], ain2 [2], ares [2];
   logic        we [2], dn [2], bs [2];
   logic [4:0]  wa [2];
   logic [31:0] wd [2];
   logic [15:0] rc0;
   logic [3:0]  rc1;
   logic [31:0] rcw [2];

   alu_issue_ctrl #(.DATA_W(32), .REG_AW(5), .ALU_LAT(1), .R0_ZERO(1), .CNT_W(16)) u_dut0 (
      .clk(clk), .rst(rst[0]), .instr_valid(iv[0]), .instr_ready(ir[0]), .instr_op(iop[0]),
      .instr_rd(ird[0]), .instr_rs(irs[0]), .instr_rt(irt[0]), .rf_raddr1(ra1[0]), .rf_raddr2(ra2[0]),
      .rf_rdata1(rd1[0]), .rf_rdata2(rd2[0]), .alu_opcode(aop[0]), .alu_in1(ain1[0]), .alu_in2(ain2[0]),
      .alu_result(ares[0]), .rf_we(we[0]), .rf_waddr(wa[0]), .rf_wdata(wd[0]), .done(dn[0]),
      .busy(bs[0]), .retired_cnt(rc0));

   alu_issue_ctrl #(.DATA_W(32), .REG_AW(5), .ALU_LAT(3), .R0_ZERO(1), .CNT_W(4)) u_dut1 (
      .clk(clk), .rst(rst[1]), .instr_valid(iv[1]), .instr_ready(ir[1]), .instr_op(iop[1]),
      .instr_rd(ird[1]), .instr_rs(irs[1]), .instr_rt(irt[1]), .rf_raddr1(ra1[1]), .rf_raddr2(ra2[1]),
      .rf_rdata1(rd1[1]), .rf_rdata2(rd2[1]), .alu_opcode(aop[1]), .alu_in1(ain1[1]), .alu_in2(ain2[1]),
      .alu_result(ares[1]), .rf_we(we[1]), .rf_waddr(wa[1]), .rf_wdata(wd[1]), .done(dn[1]),
      .busy(bs[1]), .retired_cnt(rc1));

   assign rcw[0] = {16'd0, rc0};
   assign rcw[1] = {28'd0, rc1};

   function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      case (op)
         OP_AND:  return a & b;
         OP_OR:   return a | b;
         OP_ADD:  return a + b;
         OP_SUB:  return a - b;
         OP_MIN:  return (a < b) ? a : b;
         OP_NOR:  return ~(a | b);
         OP_NAND: return ~(a & b);
         default: return a;
      endcase
   endfunction

   // Register files (combinational read, bench-side preset port) and clocked ALUs.
   logic [31:0] rf [2][32];
   logic        rf_clr;
   logic        pre_we [2];
   logic [4:0]  pre_addr [2];
   logic [31:0] pre_data [2];
   logic [31:0] p0;
   logic [31:0] p1 [3];

   always @(posedge clk) begin
      for (int l = 0; l < 2; l++) begin
         if (rf_clr) begin
            for (int r = 0; r < 32; r++) rf[l][r] <= '0;
         end else if (pre_we[l]) rf[l][pre_addr[l]] <= pre_data[l];
         else if (we[l])         rf[l][wa[l]] <= wd[l];
      end
      p0    <= alu_f(aop[0], ain1[0], ain2[0]);
      p1[0] <= alu_f(aop[1], ain1[1], ain2[1]);
      p1[1] <= p1[0];
      p1[2] <= p1[1];
   end

   assign ares[0] = p0;
   assign ares[1] = p1[2];
   assign rd1[0]  = rf[0][ra1[0]];
   assign rd2[0]  = rf[0][ra2[0]];
   assign rd1[1]  = rf[1][ra1[1]];
   assign rd2[1]  = rf[1][ra2[1]];

   int checks = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Transaction-level model: an accepted instruction retires exactly LAT+2 edges after acceptance.
   int          cyc = 0;
   bit          started = 1'b0;
   bit          pend [2], pulse [2], we_e [2];
   int          acc [2], cnt_e [2];
   logic [4:0]  q_rd [2], q_rs [2], q_rt [2], wa_e [2];
   logic [3:0]  q_op [2];
   logic [31:0] q_a [2], q_b [2], q_res [2], wd_e [2];
   logic [31:0] mrf [2][32];

   initial begin
      forever begin
         @(posedge clk);
         cyc = cyc + 1;
         for (int l = 0; l < 2; l++) begin
            if (rf_clr) begin
               for (int r = 0; r < 32; r++) mrf[l][r] = '0;
            end else if (pre_we[l]) mrf[l][pre_addr[l]] = pre_data[l];
            pulse[l] = 1'b0;
            if (rst[l]) begin
               pend[l]  = 1'b0;
               cnt_e[l] = 0;
               wa_e[l]  = '0;
               wd_e[l]  = '0;
            end else if (pend[l] && cyc == acc[l] + 2 + LAT[l]) begin
               pulse[l] = 1'b1;
               we_e[l]  = (q_rd[l] != 5'd0);
               wa_e[l]  = q_rd[l];
               wd_e[l]  = q_res[l];
               cnt_e[l] = (cnt_e[l] + 1) % CMOD[l];
               if (q_rd[l] != 5'd0) mrf[l][q_rd[l]] = q_res[l];
               pend[l]  = 1'b0;
            end else if (!pend[l] && iv[l]) begin
               pend[l]  = 1'b1;
               acc[l]   = cyc;
               q_op[l]  = iop[l];
               q_rd[l]  = ird[l];
               q_rs[l]  = irs[l];
               q_rt[l]  = irt[l];
               q_a[l]   = mrf[l][irs[l]];
               q_b[l]   = mrf[l][irt[l]];
               q_res[l] = alu_f(iop[l], q_a[l], q_b[l]);
            end
         end
         started = 1'b1;
      end
   end

   // Compare process: every output of both instances, every cycle, on the falling edge.
   initial begin
      int k;
      forever begin
         @(negedge clk);
         if (started) begin
            for (int l = 0; l < 2; l++) begin
               k = cyc - acc[l] + 1;
               check($sformatf("L%0d ready", l), ir[l], !pend[l]);
               check($sformatf("L%0d busy", l), bs[l], pend[l]);
               check($sformatf("L%0d rf_we", l), we[l], pulse[l] && we_e[l]);
               check($sformatf("L%0d done", l), dn[l], pulse[l]);
               check($sformatf("L%0d retired_cnt", l), rcw[l], cnt_e[l]);
               check($sformatf("L%0d rf_waddr", l), wa[l], wa_e[l]);
               check($sformatf("L%0d rf_wdata", l), wd[l], wd_e[l]);
               if (pend[l] && k == 1) begin
                  check($sformatf("L%0d rf_raddr1", l), ra1[l], q_rs[l]);
                  check($sformatf("L%0d rf_raddr2", l), ra2[l], q_rt[l]);
               end
               if (pend[l] && k >= 2 && k <= 1 + LAT[l]) begin
                  check($sformatf("L%0d alu_opcode", l), aop[l], q_op[l]);
                  check($sformatf("L%0d alu_in1", l), ain1[l], q_a[l]);
                  check($sformatf("L%0d alu_in2", l), ain2[l], q_b[l]);
               end
            end
         end
      end
   end

   task automatic preset(input int l, input logic [4:0] addr, input logic [31:0] data);
      @(negedge clk);
      pre_we[l]   = 1'b1;
      pre_addr[l] = addr;
      pre_data[l] = data;
      @(negedge clk);
      pre_we[l]   = 1'b0;
   endtask

   // Offers one instruction and holds it until accepted; returns in the ISSUE cycle.
   task automatic issue(input int l, input logic [3:0] op, input logic [4:0] rd,
                        input logic [4:0] rs, input logic [4:0] rt);
      int waited;
      waited = 0;
      @(negedge clk);
      iv[l]  = 1'b1;
      iop[l] = op;
      ird[l] = rd;
      irs[l] = rs;
      irt[l] = rt;
      while (!ir[l] && waited < 40) begin
         @(negedge clk);
         waited++;
      end
      check($sformatf("L%0d accept", l), ir[l], 1'b1);
      @(negedge clk);
      iv[l] = 1'b0;
   endtask

   // Counts falling edges until done, plus the cycles instr_ready was low since the call.
   task automatic wait_done(input int l, output int n, output int lowc, output logic we_at);
      n    = 0;
      lowc = ir[l] ? 0 : 1;
      while (!dn[l] && n < 20) begin
         @(negedge clk);
         n++;
         if (!ir[l]) lowc++;
      end
      check($sformatf("L%0d done seen", l), dn[l], 1'b1);
      we_at = we[l];
   endtask

   initial begin
      #600000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int   n, lowc, dcnt;
      logic wev;
      for (int l = 0; l < 2; l++) begin
         rst[l] = 1'b1; iv[l] = 1'b0; iop[l] = '0; ird[l] = '0; irs[l] = '0; irt[l] = '0;
         pre_we[l] = 1'b0; pre_addr[l] = '0; pre_data[l] = '0;
      end
      rf_clr = 1'b1;
      repeat (3) @(negedge clk);
      check("reset ready", ir[0], 1'b1);
      check("reset busy", bs[0], 1'b0);
      check("reset rf_we", we[0], 1'b0);
      check("reset done", dn[0], 1'b0);
      check("reset retired_cnt", rcw[0], 32'd0);
      check("reset alu_opcode", aop[0], 32'd0);
      check("reset alu_in1", ain1[0], 32'd0);
      check("reset rf_wdata", wd[0], 32'd0);
      check("reset rf_raddr1", ra1[0], 32'd0);
      rf_clr = 1'b0;
      rst[0] = 1'b0;
      rst[1] = 1'b0;
      @(negedge clk);

      // ADD R3 = 5 + 3
      preset(0, 5'd1, 32'd5);
      preset(0, 5'd2, 32'd3);
      issue(0, OP_ADD, 5'd3, 5'd1, 5'd2);
      wait_done(0, n, lowc, wev);
      check("add latency", n, 3);
      check("add ready low", lowc, 3);
      check("add rf_we", wev, 1'b1);
      check("add wdata", wd[0], 32'd8);
      check("add retired", rcw[0], 32'd1);
      @(negedge clk);
      check("add R3", rf[0][3], 32'd8);

      // Wrap-around ADD then SUB
      preset(0, 5'd1, 32'hFFFF_FFFF);
      preset(0, 5'd2, 32'd1);
      issue(0, OP_ADD, 5'd3, 5'd1, 5'd2);
      wait_done(0, n, lowc, wev);
      check("wrap add ready low", lowc, 3);
      @(negedge clk);
      issue(0, OP_SUB, 5'd4, 5'd2, 5'd1);
      wait_done(0, n, lowc, wev);
      check("sub ready low", lowc, 3);
      @(negedge clk);
      check("wrap R3", rf[0][3], 32'd0);
      check("sub R4", rf[0][4], 32'd2);

      // Back-to-back dependent chain
      preset(0, 5'd1, 32'hF0);
      preset(0, 5'd2, 32'h0F);
      issue(0, OP_ADD, 5'd5, 5'd1, 5'd2);
      issue(0, OP_AND, 5'd6, 5'd5, 5'd1);
      wait_done(0, n, lowc, wev);
      @(negedge clk);
      check("chain R5", rf[0][5], 32'hFF);
      check("chain R6", rf[0][6], 32'hF0);

      // Write to R0 is suppressed but still retires
      issue(0, OP_ADD, 5'd0, 5'd1, 5'd2);
      wait_done(0, n, lowc, wev);
      check("r0 rf_we", wev, 1'b0);
      @(negedge clk);
      check("r0 value", rf[0][0], 32'd0);

      // Unlisted opcode passes in1
      issue(0, 4'd9, 5'd7, 5'd1, 5'd2);
      wait_done(0, n, lowc, wev);
      @(negedge clk);
      check("pass R7", rf[0][7], 32'hF0);

      // Reset while in EXEC aborts the instruction
      issue(0, OP_ADD, 5'd8, 5'd1, 5'd2);
      @(negedge clk);
      rst[0] = 1'b1;
      @(negedge clk);
      rst[0] = 1'b0;
      check("abort busy", bs[0], 1'b0);
      check("abort retired", rcw[0], 32'd0);
      dcnt = 0;
      repeat (6) begin
         @(negedge clk);
         dcnt += int'(dn[0]) + int'(we[0]);
      end
      check("abort no pulses", dcnt, 0);
      check("abort R8", rf[0][8], 32'd0);
      issue(0, OP_ADD, 5'd9, 5'd1, 5'd2);
      wait_done(0, n, lowc, wev);
      check("after abort retired", rcw[0], 32'd1);
      @(negedge clk);
      check("after abort R9", rf[0][9], 32'hFF);

      // Randomized traffic, lane 0
      for (int r = 1; r < 32; r++) preset(0, 5'(r), $urandom);
      for (int i = 0; i < 40; i++) begin
         issue(0, 4'($urandom_range(0, 15)), 5'($urandom_range(0, 31)),
               5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
         if ($urandom_range(0, 3) == 0) repeat (4) @(negedge clk);
      end
      wait_done(0, n, lowc, wev);
      @(negedge clk);

      // Lane 1: ALU_LAT=3, 4-bit retired counter
      preset(1, 5'd1, 32'd5);
      preset(1, 5'd2, 32'd3);
      issue(1, OP_SUB, 5'd3, 5'd1, 5'd2);
      wait_done(1, n, lowc, wev);
      check("lat3 latency", n, 5);
      check("lat3 ready low", lowc, 5);
      check("lat3 retired", rcw[1], 32'd1);
      @(negedge clk);
      check("lat3 R3", rf[1][3], 32'd2);
      for (int r = 4; r < 32; r++) preset(1, 5'(r), $urandom);
      for (int i = 0; i < 14; i++) begin
         issue(1, 4'($urandom_range(0, 15)), 5'($urandom_range(0, 31)),
               5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
         if ($urandom_range(0, 3) == 0) repeat (3) @(negedge clk);
      end
      wait_done(1, n, lowc, wev);
      check("cnt at max", rcw[1], 32'd15);
      @(negedge clk);
      issue(1, OP_OR, 5'd10, 5'd1, 5'd2);
      wait_done(1, n, lowc, wev);
      check("cnt wrap", rcw[1], 32'd0);
      check("wrap latency", n, 5);
      for (int i = 0; i < 6; i++) begin
         issue(1, 4'($urandom_range(0, 15)), 5'($urandom_range(0, 31)),
               5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      end
      wait_done(1, n, lowc, wev);
      repeat (4) @(negedge clk);

      for (int l = 0; l < 2; l++) begin
         for (int r = 0; r < 32; r++) begin
            check($sformatf("L%0d final R%0d", l, r), rf[l][r], mrf[l][r]);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
